// File: rtl/extrinsic_interleaver.sv
// Extrinsic stage after the SISO decoder: captures LLR/systematic/a-priori, forms
// the saturated (optionally 0.75-scaled) extrinsic and applies the turbo (de)interleaver.
module extrinsic_interleaver #(
  parameter int                  DATA_SIZE = 12,
  parameter int                  N_ELEM    = 7,
  parameter logic [3*N_ELEM-1:0] PERM      = 21'b110_101_011_000_001_100_010,
  parameter bit                  SCALE_EN  = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic [N_ELEM*DATA_SIZE-1:0]   llr_i,
  input  logic [N_ELEM*4-1:0]           sys_i,
  input  logic [N_ELEM*DATA_SIZE-1:0]   apriori_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [N_ELEM*DATA_SIZE-1:0]   ext_o,
  output logic                          busy_o,
  output logic                          drop_o,
  output logic [7:0]                    blk_cnt_o
);

  localparam int DW = DATA_SIZE + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_PERM = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [N_ELEM*DATA_SIZE-1:0]   llr_q, llr_d;
  logic [N_ELEM*4-1:0]           sys_q, sys_d;
  logic [N_ELEM*DATA_SIZE-1:0]   apr_q, apr_d;
  logic                          mode_q, mode_d;
  logic [N_ELEM*DATA_SIZE-1:0]   e_q, e_d;
  logic [N_ELEM*DATA_SIZE-1:0]   ext_q, ext_d;
  logic                          valid_q, valid_d;
  logic                          drop_q, drop_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic                          capture;

  // The 14-bit difference is exact for every input combination; saturation happens last.
  function automatic logic [DATA_SIZE-1:0] calc_ext(input logic [DATA_SIZE-1:0] llr,
                                                    input logic [3:0]           sys,
                                                    input logic [DATA_SIZE-1:0] apr);
    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] scaled;
    diff = $signed({{2{llr[DATA_SIZE-1]}}, llr})
         - $signed({{(DW-4){sys[3]}}, sys})
         - $signed({{2{apr[DATA_SIZE-1]}}, apr});
    if (SCALE_EN) scaled = (diff >>> 1) + (diff >>> 2);
    else          scaled = diff;
    if (scaled[DW-1:DATA_SIZE-1] == '0 || scaled[DW-1:DATA_SIZE-1] == '1)
      calc_ext = scaled[DATA_SIZE-1:0];
    else if (scaled[DW-1])
      calc_ext = {1'b1, {(DATA_SIZE-1){1'b0}}};
    else
      calc_ext = {1'b0, {(DATA_SIZE-1){1'b1}}};
  endfunction

  always_comb begin
    state_d = state_q;
    llr_d   = llr_q;
    sys_d   = sys_q;
    apr_d   = apr_q;
    mode_d  = mode_q;
    e_d     = e_q;
    ext_d   = ext_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) capture = 1'b1;
      end
      ST_CALC: begin
        if (start_i) drop_d = 1'b1;
        for (int k = 0; k < N_ELEM; k++) begin
          e_d[(N_ELEM-1-k)*DATA_SIZE +: DATA_SIZE] =
            calc_ext(llr_q[(N_ELEM-1-k)*DATA_SIZE +: DATA_SIZE],
                     sys_q[(N_ELEM-1-k)*4 +: 4],
                     apr_q[(N_ELEM-1-k)*DATA_SIZE +: DATA_SIZE]);
        end
        state_d = ST_PERM;
      end
      ST_PERM: begin
        if (start_i) drop_d = 1'b1;
        for (int j = 0; j < N_ELEM; j++) begin
          if (!mode_q)
            ext_d[(N_ELEM-1-j)*DATA_SIZE +: DATA_SIZE] =
              e_q[(N_ELEM-1-int'(PERM[3*j +: 3]))*DATA_SIZE +: DATA_SIZE];
          else
            ext_d[(N_ELEM-1-int'(PERM[3*j +: 3]))*DATA_SIZE +: DATA_SIZE] =
              e_q[(N_ELEM-1-j)*DATA_SIZE +: DATA_SIZE];
        end
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (ready_i) begin
          cnt_d   = cnt_q + 8'd1;
          valid_d = 1'b0;
          if (start_i) capture = 1'b1;
          else         state_d = ST_IDLE;
        end else if (start_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A hand-off in HOLD and a fresh start in IDLE load the block the same way.
    if (capture) begin
      llr_d   = llr_i;
      sys_d   = sys_i;
      apr_d   = apriori_i;
      mode_d  = mode_i;
      state_d = ST_CALC;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      llr_q   <= '0;
      sys_q   <= '0;
      apr_q   <= '0;
      mode_q  <= 1'b0;
      e_q     <= '0;
      ext_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      llr_q   <= llr_d;
      sys_q   <= sys_d;
      apr_q   <= apr_d;
      mode_q  <= mode_d;
      e_q     <= e_d;
      ext_q   <= ext_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o   = valid_q;
  assign ext_o     = ext_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign drop_o    = drop_q;
  assign blk_cnt_o = cnt_q;

endmodule
